// File: rtl/riscv_id_pipe.sv
// RV32I decode/issue stage.
// Consumes instructions from fetch (if_id_*), reads a local 32x32 register
// file with writeback bypass, tracks in-flight destinations in a busy-bit
// scoreboard, and holds one decoded ALU/memory operation in an issue
// register handed to EX with a rdy/ack handshake (id_ex_*).
// Ports: clk, rstn (async active-low); if_id_rdy/instr/pc in, if_id_ack out
// (combinational); id_ex_rdy/funct/op1/op2/mem_funct/mem_data/wb_rsd out,
// id_ex_ack in; wb_rf_write/rsd/data in; id_illegal sticky out.

`ifndef RISCV_ID_PIPE_DEFS
`define RISCV_ID_PIPE_DEFS
`define EX_FUNCT_W  4
`define EX_ADD      4'd0
`define EX_SLL      4'd1
`define EX_SLT      4'd2
`define EX_SLTU     4'd3
`define EX_XOR      4'd4
`define EX_SRL      4'd5
`define EX_OR       4'd6
`define EX_AND      4'd7
`define EX_SUB      4'd8
`define EX_SRA      4'd9
`define MEM_FUNCT_W 4
`define MEM_NOP     4'd0
`define MEM_LB      4'd1
`define MEM_LH      4'd2
`define MEM_LW      4'd3
`define MEM_LBU     4'd4
`define MEM_LHU     4'd5
`define MEM_SB      4'd6
`define MEM_SH      4'd7
`define MEM_SW      4'd8
`endif

module riscv_id_pipe (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    if_id_rdy,
  input  logic [31:0]             if_id_instr,
  input  logic [31:0]             if_id_pc,
  output logic                    if_id_ack,
  output logic                    id_ex_rdy,
  input  logic                    id_ex_ack,
  output logic [`EX_FUNCT_W-1:0]  id_ex_funct,
  output logic [31:0]             id_ex_op1,
  output logic [31:0]             id_ex_op2,
  output logic [`MEM_FUNCT_W-1:0] id_ex_mem_funct,
  output logic [31:0]             id_ex_mem_data,
  output logic [4:0]              id_ex_wb_rsd,
  input  logic                    wb_rf_write,
  input  logic [4:0]              wb_rf_rsd,
  input  logic [31:0]             wb_rf_data,
  output logic                    id_illegal
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  // Instruction fields
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;

  assign opcode = if_id_instr[6:0];
  assign rd     = if_id_instr[11:7];
  assign funct3 = if_id_instr[14:12];
  assign rs1    = if_id_instr[19:15];
  assign rs2    = if_id_instr[24:20];
  assign funct7 = if_id_instr[31:25];
  assign imm_i  = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
  assign imm_s  = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
  assign imm_u  = {if_id_instr[31:12], 12'b0};

  // Register file (not reset) with same-cycle writeback bypass
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            rs1_wr, rs2_wr;

  assign rs1_wr  = wb_rf_write && (wb_rf_rsd == rs1);
  assign rs2_wr  = wb_rf_write && (wb_rf_rsd == rs2);
  assign rs1_val = (rs1 == 5'd0) ? '0 : (rs1_wr ? wb_rf_data : rf_q[rs1]);
  assign rs2_val = (rs2 == 5'd0) ? '0 : (rs2_wr ? wb_rf_data : rf_q[rs2]);

  always_ff @(posedge clk) begin
    if (wb_rf_write && (wb_rf_rsd != 5'd0)) rf_q[wb_rf_rsd] <= wb_rf_data;
  end

  // funct3 -> ALU function; alt selects SUB/SRA
  function automatic logic [`EX_FUNCT_W-1:0] alu_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_funct = alt ? `EX_SUB : `EX_ADD;
      3'b001:  alu_funct = `EX_SLL;
      3'b010:  alu_funct = `EX_SLT;
      3'b011:  alu_funct = `EX_SLTU;
      3'b100:  alu_funct = `EX_XOR;
      3'b101:  alu_funct = alt ? `EX_SRA : `EX_SRL;
      3'b110:  alu_funct = `EX_OR;
      default: alu_funct = `EX_AND;
    endcase
  endfunction

  // Decode
  logic                    dec_legal, rs1_used, rs2_used;
  logic [4:0]              dec_rd;
  logic [`EX_FUNCT_W-1:0]  dec_funct;
  logic [`MEM_FUNCT_W-1:0] dec_mem_funct;
  logic [XLEN-1:0]         dec_op1, dec_op2, dec_mem_data;

  always_comb begin
    dec_legal     = 1'b0;
    rs1_used      = 1'b0;
    rs2_used      = 1'b0;
    dec_rd        = 5'd0;
    dec_funct     = `EX_ADD;
    dec_mem_funct = `MEM_NOP;
    dec_op1       = '0;
    dec_op2       = '0;
    dec_mem_data  = '0;
    case (opcode)
      OPC_OP: begin
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        dec_rd    = rd;
        dec_op1   = rs1_val;
        dec_op2   = rs2_val;
        dec_funct = alu_funct(funct3, funct7[5]);
        dec_legal = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OPIMM: begin
        rs1_used  = 1'b1;
        dec_rd    = rd;
        dec_op1   = rs1_val;
        dec_funct = alu_funct(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_op2   = {27'b0, if_id_instr[24:20]};
          dec_legal = (funct7 == 7'b0000000) || ((funct3 == 3'b101) && (funct7 == 7'b0100000));
        end else begin
          dec_op2   = imm_i;
          dec_legal = 1'b1;
        end
      end
      OPC_LOAD: begin
        rs1_used  = 1'b1;
        dec_rd    = rd;
        dec_op1   = rs1_val;
        dec_op2   = imm_i;
        dec_legal = 1'b1;
        case (funct3)
          3'b000:  dec_mem_funct = `MEM_LB;
          3'b001:  dec_mem_funct = `MEM_LH;
          3'b010:  dec_mem_funct = `MEM_LW;
          3'b100:  dec_mem_funct = `MEM_LBU;
          3'b101:  dec_mem_funct = `MEM_LHU;
          default: dec_legal     = 1'b0;
        endcase
      end
      OPC_STORE: begin
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
        dec_op1      = rs1_val;
        dec_op2      = imm_s;
        dec_mem_data = rs2_val;
        dec_legal    = 1'b1;
        case (funct3)
          3'b000:  dec_mem_funct = `MEM_SB;
          3'b001:  dec_mem_funct = `MEM_SH;
          3'b010:  dec_mem_funct = `MEM_SW;
          default: dec_legal     = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec_rd    = rd;
        dec_op2   = imm_u;
        dec_legal = 1'b1;
      end
      OPC_AUIPC: begin
        dec_rd    = rd;
        dec_op1   = if_id_pc;
        dec_op2   = imm_u;
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Hazard and handshake; illegal instructions are dropped regardless of hazards
  logic [NREGS-1:0] busy_q, busy_d;
  logic             hazard, slot_free, load_en;

  assign hazard    = (rs1_used && busy_q[rs1] && !rs1_wr) ||
                     (rs2_used && busy_q[rs2] && !rs2_wr) ||
                     ((dec_rd != 5'd0) && busy_q[dec_rd]);
  assign slot_free = !id_ex_rdy || id_ex_ack;
  assign if_id_ack = if_id_rdy && slot_free && (!dec_legal || !hazard);
  assign load_en   = if_id_ack && dec_legal;

  // Next-state: scoreboard (set beats clear), issue register, sticky illegal
  logic                    rdy_d, illegal_d;
  logic [`EX_FUNCT_W-1:0]  funct_d;
  logic [`MEM_FUNCT_W-1:0] mem_funct_d;
  logic [XLEN-1:0]         op1_d, op2_d, mem_data_d;
  logic [4:0]              wb_rsd_d;

  always_comb begin
    busy_d      = busy_q;
    rdy_d       = id_ex_rdy;
    funct_d     = id_ex_funct;
    op1_d       = id_ex_op1;
    op2_d       = id_ex_op2;
    mem_funct_d = id_ex_mem_funct;
    mem_data_d  = id_ex_mem_data;
    wb_rsd_d    = id_ex_wb_rsd;
    illegal_d   = id_illegal || (if_id_ack && !dec_legal);
    if (wb_rf_write) busy_d[wb_rf_rsd] = 1'b0;
    if (load_en) begin
      if (dec_rd != 5'd0) busy_d[dec_rd] = 1'b1;
      rdy_d       = 1'b1;
      funct_d     = dec_funct;
      op1_d       = dec_op1;
      op2_d       = dec_op2;
      mem_funct_d = dec_mem_funct;
      mem_data_d  = dec_mem_data;
      wb_rsd_d    = dec_rd;
    end else if (id_ex_ack) begin
      rdy_d = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q          <= '0;
      id_ex_rdy       <= 1'b0;
      id_ex_funct     <= `EX_ADD;
      id_ex_op1       <= '0;
      id_ex_op2       <= '0;
      id_ex_mem_funct <= `MEM_NOP;
      id_ex_mem_data  <= '0;
      id_ex_wb_rsd    <= 5'd0;
      id_illegal      <= 1'b0;
    end else begin
      busy_q          <= busy_d;
      id_ex_rdy       <= rdy_d;
      id_ex_funct     <= funct_d;
      id_ex_op1       <= op1_d;
      id_ex_op2       <= op2_d;
      id_ex_mem_funct <= mem_funct_d;
      id_ex_mem_data  <= mem_data_d;
      id_ex_wb_rsd    <= wb_rsd_d;
      id_illegal      <= illegal_d;
    end
  end

endmodule
